mips_div_ctrl: RTL and testbench

MIPS_DIV_CTRL -- requirements
Module: mips_div_ctrl

---
 rtl/mips_div_pkg.sv | 29 ++
 rtl/mips_div_wdog.sv | 48 ++++
 rtl/mips_div_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mips_div_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// mips_div_pkg -- shared definitions for the MIPS divide controller slice.
//
// Contents:
//   OPDATA_WIDTH_DEF  default operand width used by mips_div_ctrl
//   div_state_e       controller state encoding (IDLE, BUSY, DONE, DRAIN)
//   HI_FIELD/LO_FIELD word index of remainder/quotient inside the divider
//                     result bus {remainder, quotient}
//   field_lsb()       helper returning the LSB position of a result field

package mips_div_pkg;

  localparam int OPDATA_WIDTH_DEF = 32;

  // Result bus is {HI, LO}: the quotient sits in word 0, the remainder in word 1.
  localparam int LO_FIELD = 0;
  localparam int HI_FIELD = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } div_state_e;

  function automatic int field_lsb(input int field, input int width);
    return field * width;
  endfunction

endpackage

// File: rtl/mips_div_wdog.sv
// mips_div_wdog -- BUSY-cycle watchdog for the divide controller.
//
// Only instantiated when MIPS_DIV_CTRL_TIMEOUT_EN is defined.
//
// Ports:
//   clk       clock, all state on rising edge
//   rst_n     synchronous active-low reset
//   clear_i   restart the count (controller accepting a new divide)
//   en_i      controller is in BUSY this cycle
//   expire_o  this BUSY cycle is number TIMEOUT_CYCLES without a result

module mips_div_wdog #(
  parameter int TIMEOUT_CYCLES = 80
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The count holds the number of BUSY cycles already completed, so the
  // first BUSY cycle sees 0 and the TIMEOUT_CYCLES-th sees TIMEOUT_CYCLES-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mips_div_ctrl.sv
// mips_div_ctrl -- EX-stage controller for a multi-cycle MIPS div/divu unit.
//
// Accepts a divide request from EX, stalls the pipeline while the external
// divider works, writes HI (remainder) / LO (quotient) once on completion,
// and annuls the divider on a pipeline flush.
//
// Optional feature: define MIPS_DIV_CTRL_TIMEOUT_EN to add a BUSY watchdog
// (mips_div_wdog) that aborts the divide after TIMEOUT_CYCLES and pulses
// div_err_o. Without it div_err_o is tied low and BUSY waits indefinitely.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   div_req_i, div_signed_i    request (level) and div/divu select
//   div_op1_i, div_op2_i       dividend, divisor
//   flush_i                    pipeline flush, cancels in-flight divide
//   stall_req_o                stall request to pipeline control
//   hilo_we_o, hi_o, lo_o      HI/LO write strobe and registered result
//   div_start_o, div_annul_o   divider run / abort controls
//   div_signed_o, div_op*_o    latched operands to the divider
//   div_result_i, div_valid_i  divider result {remainder, quotient}, valid
//   div_err_o                  watchdog timeout pulse

module mips_div_ctrl
  import mips_div_pkg::*;
#(
  parameter int OPDATA_WIDTH   = OPDATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 80
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      div_req_i,
  input  logic                      div_signed_i,
  input  logic [OPDATA_WIDTH-1:0]   div_op1_i,
  input  logic [OPDATA_WIDTH-1:0]   div_op2_i,
  input  logic                      flush_i,
  output logic                      stall_req_o,
  output logic                      hilo_we_o,
  output logic [OPDATA_WIDTH-1:0]   hi_o,
  output logic [OPDATA_WIDTH-1:0]   lo_o,
  output logic                      div_start_o,
  output logic                      div_annul_o,
  output logic                      div_signed_o,
  output logic [OPDATA_WIDTH-1:0]   div_op1_o,
  output logic [OPDATA_WIDTH-1:0]   div_op2_o,
  input  logic [2*OPDATA_WIDTH-1:0] div_result_i,
  input  logic                      div_valid_i,
  output logic                      div_err_o
);

  localparam int HI_LSB = field_lsb(HI_FIELD, OPDATA_WIDTH);
  localparam int LO_LSB = field_lsb(LO_FIELD, OPDATA_WIDTH);

  div_state_e state_q, state_d;

  logic                    signed_q;
  logic [OPDATA_WIDTH-1:0] op1_q, op2_q;
  logic [OPDATA_WIDTH-1:0] hi_q, lo_q;

  logic accept;
  logic timeout_hit;

`ifdef MIPS_DIV_CTRL_TIMEOUT_EN
  mips_div_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .en_i    (state_q == ST_BUSY),
    .expire_o(timeout_hit)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // Next state and all handshake outputs. Flush beats a simultaneous result,
  // and a result beats a simultaneous watchdog expiry. A stale div_valid_i
  // (divider still finishing an annulled op) blocks acceptance in IDLE and
  // keeps DONE/DRAIN from returning to IDLE. Every strobe is forced low
  // while rst_n is asserted so nothing leaks out during reset.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    stall_req_o = 1'b0;
    hilo_we_o   = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    div_err_o   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (div_req_i) begin
          stall_req_o = 1'b1;
          if (!flush_i && !div_valid_i) begin
            accept  = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_d     = ST_DRAIN;
        end else if (div_valid_i) begin
          div_start_o = 1'b1;
          hilo_we_o   = 1'b1;
          state_d     = ST_DONE;
        end else if (timeout_hit) begin
          div_err_o   = 1'b1;
          div_annul_o = 1'b1;
          state_d     = ST_DRAIN;
        end else begin
          div_start_o = 1'b1;
          stall_req_o = 1'b1;
        end
      end
      ST_DONE, ST_DRAIN: begin
        stall_req_o = div_req_i;
        if (!div_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!rst_n) begin
      accept      = 1'b0;
      stall_req_o = 1'b0;
      hilo_we_o   = 1'b0;
      div_start_o = 1'b0;
      div_annul_o = 1'b0;
      div_err_o   = 1'b0;
    end
  end

  // Operands are captured only on acceptance so the divider sees them stable
  // for the whole operation; HI/LO only change on the write strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        signed_q <= div_signed_i;
        op1_q    <= div_op1_i;
        op2_q    <= div_op2_i;
      end
      if (hilo_we_o) begin
        hi_q <= div_result_i[HI_LSB +: OPDATA_WIDTH];
        lo_q <= div_result_i[LO_LSB +: OPDATA_WIDTH];
      end
    end
  end

  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule

// File: tb/tb_mips_div_ctrl.sv
// tb_mips_div_ctrl -- directed bench for mips_div_ctrl.
//
// The bench stands in for the divider: it drives div_valid_i/div_result_i
// with hand-computed {remainder, quotient} values. Inputs change on the
// falling edge and outputs are sampled 1 ns later, well clear of the rising
// edge. Define MIPS_DIV_CTRL_TIMEOUT_EN to exercise the watchdog path.

module tb_mips_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] div_op1_i;
  logic [31:0] div_op2_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic [63:0] div_result_i;
  logic        div_valid_i;
  logic        div_err_o;

  int total;
  int bad;
  int weCount;

  mips_div_ctrl #(
    .OPDATA_WIDTH  (32),
    .TIMEOUT_CYCLES(80)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_req_i   (div_req_i),
    .div_signed_i(div_signed_i),
    .div_op1_i   (div_op1_i),
    .div_op2_i   (div_op2_i),
    .flush_i     (flush_i),
    .stall_req_o (stall_req_o),
    .hilo_we_o   (hilo_we_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .div_start_o (div_start_o),
    .div_annul_o (div_annul_o),
    .div_signed_o(div_signed_o),
    .div_op1_o   (div_op1_o),
    .div_op2_o   (div_op2_o),
    .div_result_i(div_result_i),
    .div_valid_i (div_valid_i),
    .div_err_o   (div_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, let combinational outputs
  // settle, and tally every HI/LO write strobe seen during the run.
  task automatic applyStimulus(input logic rstn, input logic req, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic fl, input logic vld,
                               input logic [63:0] res);
    @(negedge clk);
    rst_n        = rstn;
    div_req_i    = req;
    div_signed_i = sgn;
    div_op1_i    = a;
    div_op2_i    = b;
    flush_i      = fl;
    div_valid_i  = vld;
    div_result_i = res;
    #1;
    if (hilo_we_o === 1'b1) weCount++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    weCount = 0;
    rst_n = 1'b0; div_req_i = 1'b0; div_signed_i = 1'b0;
    div_op1_i = '0; div_op2_i = '0; flush_i = 1'b0;
    div_valid_i = 1'b0; div_result_i = '0;

    // Reset: strobes gated low even with a request present, registers cleared
    applyStimulus(0, 1, 0, 32'd100, 32'd7, 0, 0, 64'd0);
    checkOutput("rst_stall", stall_req_o, 32'd0);
    checkOutput("rst_we",    hilo_we_o,   32'd0);
    checkOutput("rst_start", div_start_o, 32'd0);
    checkOutput("rst_annul", div_annul_o, 32'd0);
    checkOutput("rst_err",   div_err_o,   32'd0);
    applyStimulus(0, 1, 0, 32'd100, 32'd7, 0, 0, 64'd0);
    checkOutput("rst_hi",  hi_o,      32'd0);
    checkOutput("rst_lo",  lo_o,      32'd0);
    checkOutput("rst_op1", div_op1_o, 32'd0);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0);
    checkOutput("idle_stall", stall_req_o, 32'd0);

    // divu 100/7 -> q=14, r=2
    applyStimulus(1, 1, 0, 32'd100, 32'd7, 0, 0, 64'd0);
    checkOutput("a_accept_stall", stall_req_o, 32'd1);
    checkOutput("a_accept_start", div_start_o, 32'd0);
    applyStimulus(1, 1, 0, 32'd100, 32'd7, 0, 0, 64'd0);
    checkOutput("a_busy_start", div_start_o,  32'd1);
    checkOutput("a_busy_stall", stall_req_o,  32'd1);
    checkOutput("a_op1",        div_op1_o,    32'd100);
    checkOutput("a_op2",        div_op2_o,    32'd7);
    checkOutput("a_signed",     div_signed_o, 32'd0);
    checkOutput("a_busy_we",    hilo_we_o,    32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 32'd100, 32'd7, 0, 0, 64'd0);
      checkOutput("a_busy_hold", stall_req_o, 32'd1);
    end
    applyStimulus(1, 1, 0, 32'd100, 32'd7, 0, 1, {32'd2, 32'd14});
    checkOutput("a_valid_we",    hilo_we_o,   32'd1);
    checkOutput("a_valid_stall", stall_req_o, 32'd0);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0);
    checkOutput("a_hi",         hi_o,        32'h2);
    checkOutput("a_lo",         lo_o,        32'hE);
    checkOutput("a_done_we",    hilo_we_o,   32'd0);
    checkOutput("a_done_start", div_start_o, 32'd0);
    checkOutput("a_we_count",   weCount,     32'd1);

    // Stale div_valid_i in IDLE blocks acceptance, then div -7/2 -> q=-3, r=-1
    applyStimulus(1, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, 1, 64'd0);
    checkOutput("b_stale_stall", stall_req_o, 32'd1);
    applyStimulus(1, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'd0);
    checkOutput("b_stale_noacc", div_start_o, 32'd0);
    applyStimulus(1, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'd0);
    checkOutput("b_signed", div_signed_o, 32'd1);
    checkOutput("b_op1",    div_op1_o,    32'hFFFF_FFF9);
    applyStimulus(1, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    checkOutput("b_valid_we", hilo_we_o, 32'd1);

    // New divu 5/0 arrives in DONE: stalled there, accepted from IDLE
    applyStimulus(1, 1, 0, 32'd5, 32'd0, 0, 0, 64'd0);
    checkOutput("c_done_stall", stall_req_o, 32'd1);
    checkOutput("c_done_start", div_start_o, 32'd0);
    checkOutput("b_hi", hi_o, 32'hFFFF_FFFF);
    checkOutput("b_lo", lo_o, 32'hFFFF_FFFD);
    applyStimulus(1, 1, 0, 32'd5, 32'd0, 0, 0, 64'd0);
    checkOutput("c_idle_stall", stall_req_o, 32'd1);
    checkOutput("c_idle_start", div_start_o, 32'd0);
    applyStimulus(1, 1, 0, 32'd5, 32'd0, 0, 0, 64'd0);
    checkOutput("c_op1", div_op1_o, 32'd5);
    checkOutput("c_op2", div_op2_o, 32'd0);
    applyStimulus(1, 1, 0, 32'd5, 32'd0, 0, 1, 64'd0);
    checkOutput("c_valid_we", hilo_we_o, 32'd1);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0);
    checkOutput("c_hi",       hi_o,    32'd0);
    checkOutput("c_lo",       lo_o,    32'd0);
    checkOutput("c_we_count", weCount, 32'd3);

    // divu 20/4 flushed on BUSY cycle 10 together with a result
    applyStimulus(1, 1, 0, 32'd20, 32'd4, 0, 0, 64'd0);
    for (int i = 1; i < 10; i++) begin
      applyStimulus(1, 1, 0, 32'd20, 32'd4, 0, 0, 64'd0);
    end
    checkOutput("d_busy9_start", div_start_o, 32'd1);
    applyStimulus(1, 1, 0, 32'd20, 32'd4, 1, 1, {32'd1, 32'd1});
    checkOutput("d_flush_annul", div_annul_o, 32'd1);
    checkOutput("d_flush_we",    hilo_we_o,   32'd0);
    checkOutput("d_flush_start", div_start_o, 32'd0);
    checkOutput("d_flush_stall", stall_req_o, 32'd0);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 1, {32'd1, 32'd1});
    checkOutput("d_drain_annul", div_annul_o, 32'd0);
    checkOutput("d_drain_start", div_start_o, 32'd0);
    checkOutput("d_drain_we",    hilo_we_o,   32'd0);

    // Back-to-back divu 9/3 -> q=3, r=0
    applyStimulus(1, 1, 0, 32'd9, 32'd3, 0, 0, 64'd0);
    checkOutput("e_drain_stall", stall_req_o, 32'd1);
    checkOutput("e_drain_start", div_start_o, 32'd0);
    applyStimulus(1, 1, 0, 32'd9, 32'd3, 0, 0, 64'd0);
    checkOutput("e_idle_stall", stall_req_o, 32'd1);
    applyStimulus(1, 1, 0, 32'd9, 32'd3, 0, 0, 64'd0);
    checkOutput("e_busy_start", div_start_o, 32'd1);
    applyStimulus(1, 1, 0, 32'd9, 32'd3, 0, 1, {32'd0, 32'd3});
    checkOutput("e_valid_we", hilo_we_o, 32'd1);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0);
    checkOutput("e_hi",       hi_o,    32'd0);
    checkOutput("e_lo",       lo_o,    32'd3);
    checkOutput("e_we_count", weCount, 32'd4);

    // Divider never answers: watchdog (if built) fires on BUSY cycle 80
    applyStimulus(1, 1, 0, 32'd1, 32'd1, 0, 0, 64'd0);
    for (int i = 1; i < 80; i++) begin
      applyStimulus(1, 1, 0, 32'd1, 32'd1, 0, 0, 64'd0);
    end
    checkOutput("f_busy79_err",   div_err_o,   32'd0);
    checkOutput("f_busy79_start", div_start_o, 32'd1);
`ifdef MIPS_DIV_CTRL_TIMEOUT_EN
    applyStimulus(1, 1, 0, 32'd1, 32'd1, 0, 0, 64'd0);
    checkOutput("f_to_err",   div_err_o,   32'd1);
    checkOutput("f_to_annul", div_annul_o, 32'd1);
    checkOutput("f_to_stall", stall_req_o, 32'd0);
    checkOutput("f_to_we",    hilo_we_o,   32'd0);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0);
    checkOutput("f_drain_err", div_err_o, 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 0, 32'd1, 32'd1, 0, 0, 64'd0);
    end
    checkOutput("f_noto_err",   div_err_o,   32'd0);
    checkOutput("f_noto_stall", stall_req_o, 32'd1);
    applyStimulus(1, 1, 0, 32'd1, 32'd1, 1, 0, 64'd0);
    checkOutput("f_flush_annul", div_annul_o, 32'd1);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0);
`endif
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0);
    checkOutput("f_idle_start", div_start_o, 32'd0);
    checkOutput("f_we_count",   weCount,     32'd4);

    // Reset in the middle of divu 50/5 abandons it without a write
    applyStimulus(1, 1, 0, 32'd50, 32'd5, 0, 0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 32'd50, 32'd5, 0, 0, 64'd0);
    end
    checkOutput("g_op1", div_op1_o, 32'd50);
    applyStimulus(0, 1, 0, 32'd50, 32'd5, 0, 1, {32'd0, 32'd10});
    checkOutput("g_rst_we",    hilo_we_o,   32'd0);
    checkOutput("g_rst_stall", stall_req_o, 32'd0);
    checkOutput("g_rst_start", div_start_o, 32'd0);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, 0, 0, 64'd0);
    checkOutput("g_hi",       hi_o,        32'd0);
    checkOutput("g_lo",       lo_o,        32'd0);
    checkOutput("g_op1_clr",  div_op1_o,   32'd0);
    checkOutput("g_idle",     div_start_o, 32'd0);
    checkOutput("g_we_count", weCount,     32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
